// File: rtl/fp_cmp_pkg.sv
// fp_cmp_pkg: shared definitions for the fp_cmp_reduce comparator.
//   - op_e        : per-beat operation codes (LT..GE pairwise, RMIN reduction, reserved).
//   - state_e     : reduction state machine encodings.
//   - fp_unpacked_t: unpacked sign/exp/frac operand at the default widths.
//   - cmp_parts_t : compare partials produced by fp_cmp_core and registered in stage s1.
//   - parts_lt/parts_eq: fold partials into the final ordering.
package fp_cmp_pkg;

    localparam int unsigned FP_EXP_W  = 6;
    localparam int unsigned FP_FRAC_W = 14;
    localparam int unsigned FP_TAG_W  = 16;
    localparam int unsigned FP_IDX_W  = 8;

    typedef enum logic [2:0] {
        OP_LT   = 3'd0,
        OP_LE   = 3'd1,
        OP_EQ   = 3'd2,
        OP_NE   = 3'd3,
        OP_GT   = 3'd4,
        OP_GE   = 3'd5,
        OP_RMIN = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    typedef struct packed {
        logic                      sign;
        logic signed [FP_EXP_W:0]  exp;
        logic        [FP_FRAC_W:0] frac;
    } fp_unpacked_t;

    typedef struct packed {
        logic sign_a;
        logic sign_diff;
        logic exp_lt;
        logic exp_eq;
        logic frac_lt;
        logic frac_eq;
        logic zero_a;
        logic zero_b;
    } cmp_parts_t;

    // Zero is any frac == 0, so zeros are resolved before exp/frac are consulted.
    function automatic logic parts_lt(cmp_parts_t p);
        logic sign_b;
        logic mag_lt;
        logic mag_eq;
        sign_b = p.sign_a ^ p.sign_diff;
        mag_lt = p.exp_lt | (p.exp_eq & p.frac_lt);
        mag_eq = p.exp_eq & p.frac_eq;
        if (p.zero_a && p.zero_b) begin
            return 1'b0;
        end else if (p.zero_a) begin
            return ~sign_b;
        end else if (p.zero_b) begin
            return p.sign_a;
        end else if (p.sign_diff) begin
            return p.sign_a;
        end else if (p.sign_a) begin
            return ~(mag_lt | mag_eq);
        end
        return mag_lt;
    endfunction

    function automatic logic parts_eq(cmp_parts_t p);
        return (p.zero_a & p.zero_b) | (~p.sign_diff & p.exp_eq & p.frac_eq);
    endfunction

endpackage

// File: rtl/fp_cmp_reduce_if.sv
// fp_cmp_reduce_if: input beat and result stream of fp_cmp_reduce.
//   Input side : in_valid/in_ready, op, in_last, operand A/B (sign/exp/frac), in_tag.
//   Output side: out_valid/out_ready, out_result, out_is_reduce, out_sign/exp/frac, out_tag,
//                and out_idx when FP_CMP_ARGMIN_IDX_EN is defined.
//   modport master: producer of beats / consumer of results (testbench side).
//   modport slave : the comparator.
interface fp_cmp_reduce_if #(
    parameter int unsigned EXP_W  = 6,
    parameter int unsigned FRAC_W = 14,
    parameter int unsigned TAG_W  = 16,
    parameter int unsigned IDX_W  = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [2:0]               op;
    logic                     in_last;
    logic                     sign_a;
    logic signed [EXP_W:0]    exp_a;
    logic        [FRAC_W:0]   frac_a;
    logic                     sign_b;
    logic signed [EXP_W:0]    exp_b;
    logic        [FRAC_W:0]   frac_b;
    logic [TAG_W-1:0]         in_tag;

    logic                     out_valid;
    logic                     out_ready;
    logic                     out_result;
    logic                     out_is_reduce;
    logic                     out_sign;
    logic signed [EXP_W:0]    out_exp;
    logic        [FRAC_W:0]   out_frac;
    logic [TAG_W-1:0]         out_tag;
`ifdef FP_CMP_ARGMIN_IDX_EN
    logic [IDX_W-1:0]         out_idx;
`else
    localparam int unsigned unused_idx_w = IDX_W;
`endif

    modport master (
        output in_valid, op, in_last, sign_a, exp_a, frac_a, sign_b, exp_b, frac_b, in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid, out_result, out_is_reduce, out_sign, out_exp, out_frac, out_tag
`ifdef FP_CMP_ARGMIN_IDX_EN
        , input out_idx
`endif
    );

    modport slave (
        input  in_valid, op, in_last, sign_a, exp_a, frac_a, sign_b, exp_b, frac_b, in_tag,
        input  out_ready,
        output in_ready,
        output out_valid, out_result, out_is_reduce, out_sign, out_exp, out_frac, out_tag
`ifdef FP_CMP_ARGMIN_IDX_EN
        , output out_idx
`endif
    );

endinterface

// File: rtl/fp_cmp_core.sv
// fp_cmp_core: combinational ordering of two unpacked floats.
//   Inputs : sign_a/exp_a/frac_a, sign_b/exp_b/frac_b (exp signed, hidden bit explicit).
//   Outputs: parts (raw sign/exp/frac partials), lt (A < B), eq (A == B, +0 == -0).
module fp_cmp_core
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W  = FP_EXP_W,
    parameter int unsigned FRAC_W = FP_FRAC_W
) (
    input  logic                  sign_a,
    input  logic signed [EXP_W:0] exp_a,
    input  logic [FRAC_W:0]       frac_a,
    input  logic                  sign_b,
    input  logic signed [EXP_W:0] exp_b,
    input  logic [FRAC_W:0]       frac_b,
    output cmp_parts_t            parts,
    output logic                  lt,
    output logic                  eq
);

    always_comb begin
        parts           = '0;
        parts.sign_a    = sign_a;
        parts.sign_diff = sign_a ^ sign_b;
        parts.exp_lt    = exp_a < exp_b;
        parts.exp_eq    = exp_a == exp_b;
        parts.frac_lt   = frac_a < frac_b;
        parts.frac_eq   = frac_a == frac_b;
        parts.zero_a    = frac_a == '0;
        parts.zero_b    = frac_b == '0;
    end

    assign lt = parts_lt(parts);
    assign eq = parts_eq(parts);

endmodule

// File: rtl/fp_cmp_reduce.sv
// fp_cmp_reduce: two-stage pipelined float comparator with streaming minimum reduction.
//   clk : rising-edge clock.
//   rst : synchronous active-high reset; drops any partial reduction.
//   bus : fp_cmp_reduce_if.slave -- beat input (valid/ready) and result output (valid/ready).
// Pairwise ops (LT..GE, 7 = LT) produce one result per beat with A echoed on out_sign/exp/frac.
// RMIN packets produce one result on the in_last beat carrying the minimum and its tag.
// Optional macro FP_CMP_ARGMIN_IDX_EN adds out_idx, the in-packet index of the winning beat.
module fp_cmp_reduce
    import fp_cmp_pkg::*;
#(
    parameter int unsigned EXP_W  = FP_EXP_W,
    parameter int unsigned FRAC_W = FP_FRAC_W,
    parameter int unsigned TAG_W  = FP_TAG_W,
    parameter int unsigned IDX_W  = FP_IDX_W
) (
    input logic            clk,
    input logic            rst,
    fp_cmp_reduce_if.slave bus
);

    typedef struct packed {
        logic                  sign;
        logic signed [EXP_W:0] exp;
        logic [FRAC_W:0]       frac;
    } fp_t;

    state_e           state;
    fp_t              op_a;
    fp_t              best;
    fp_t              best_nxt;
    logic [TAG_W-1:0] best_tag;
    logic [TAG_W-1:0] best_tag_nxt;

    logic             stall;
    logic             accept;
    logic             rmin_beat;
    logic             pass;
    logic             emit;

    cmp_parts_t       pair_parts;
    cmp_parts_t       red_parts;
    logic             pair_lt;
    logic             pair_eq;
    logic             red_lt;
    logic             red_eq;

    logic             s1_valid;
    logic             s1_reduce;
    op_e              s1_op;
    cmp_parts_t       s1_parts;
    fp_t              s1_val;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_lt;
    logic             s1_eq;
    logic             s1_pred;

`ifdef FP_CMP_ARGMIN_IDX_EN
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] cnt_nxt;
    logic [IDX_W-1:0] best_idx;
    logic [IDX_W-1:0] best_idx_nxt;
    logic [IDX_W-1:0] s1_idx;
`else
    localparam int unsigned unused_idx_w = IDX_W;
`endif

    // The pairwise path only needs the registered partials; the RMIN path only needs lt.
    logic unused_cmp;
    assign unused_cmp = ^{pair_lt, pair_eq, red_parts, red_eq};

    // Whole pipeline freezes as one unit while the output is held.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;
    assign accept       = bus.in_valid && !stall;

    // Inside a packet every beat is RMIN regardless of its op field.
    assign rmin_beat = (state == ST_ACCUM) || (op_e'(bus.op) == OP_RMIN);
    assign pass      = accept && !rmin_beat;
    assign emit      = accept && rmin_beat && bus.in_last;

    always_comb begin
        op_a      = '0;
        op_a.sign = bus.sign_a;
        op_a.exp  = bus.exp_a;
        op_a.frac = bus.frac_a;
    end

    fp_cmp_core #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_cmp_pair (
        .sign_a (bus.sign_a),
        .exp_a  (bus.exp_a),
        .frac_a (bus.frac_a),
        .sign_b (bus.sign_b),
        .exp_b  (bus.exp_b),
        .frac_b (bus.frac_b),
        .parts  (pair_parts),
        .lt     (pair_lt),
        .eq     (pair_eq)
    );

    fp_cmp_core #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_cmp_best (
        .sign_a (bus.sign_a),
        .exp_a  (bus.exp_a),
        .frac_a (bus.frac_a),
        .sign_b (best.sign),
        .exp_b  (best.exp),
        .frac_b (best.frac),
        .parts  (red_parts),
        .lt     (red_lt),
        .eq     (red_eq)
    );

    // Strict lt keeps the earliest beat on ties.
    always_comb begin
        best_nxt     = best;
        best_tag_nxt = best_tag;
        if (state == ST_IDLE || red_lt) begin
            best_nxt     = op_a;
            best_tag_nxt = bus.in_tag;
        end
`ifdef FP_CMP_ARGMIN_IDX_EN
        best_idx_nxt = best_idx;
        cnt_nxt      = cnt + 1'b1;
        if (state == ST_IDLE) begin
            best_idx_nxt = '0;
            cnt_nxt      = IDX_W'(1);
        end else if (red_lt) begin
            best_idx_nxt = cnt;
        end
        if (bus.in_last) begin
            cnt_nxt = '0;
        end
`endif
    end

    always_comb begin
        s1_lt   = parts_lt(s1_parts);
        s1_eq   = parts_eq(s1_parts);
        s1_pred = 1'b0;
        unique case (s1_op)
            OP_LT, OP_RSVD: s1_pred = s1_lt;
            OP_LE:          s1_pred = s1_lt | s1_eq;
            OP_EQ:          s1_pred = s1_eq;
            OP_NE:          s1_pred = ~s1_eq;
            OP_GT:          s1_pred = ~(s1_lt | s1_eq);
            OP_GE:          s1_pred = ~s1_lt;
            OP_RMIN:        s1_pred = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            best              <= '0;
            best_tag          <= '0;
            s1_valid          <= 1'b0;
            s1_reduce         <= 1'b0;
            s1_op             <= OP_LT;
            s1_parts          <= '0;
            s1_val            <= '0;
            s1_tag            <= '0;
            bus.out_valid     <= 1'b0;
            bus.out_result    <= 1'b0;
            bus.out_is_reduce <= 1'b0;
            bus.out_sign      <= 1'b0;
            bus.out_exp       <= '0;
            bus.out_frac      <= '0;
            bus.out_tag       <= '0;
`ifdef FP_CMP_ARGMIN_IDX_EN
            cnt               <= '0;
            best_idx          <= '0;
            s1_idx            <= '0;
            bus.out_idx       <= '0;
`endif
        end else if (!stall) begin
            // Stage s1: partials plus reduction update; non-last RMIN beats become bubbles.
            s1_valid  <= pass || emit;
            s1_reduce <= emit;
            s1_op     <= op_e'(bus.op);
            s1_parts  <= pair_parts;
            s1_val    <= emit ? best_nxt : op_a;
            s1_tag    <= emit ? best_tag_nxt : bus.in_tag;
`ifdef FP_CMP_ARGMIN_IDX_EN
            s1_idx    <= emit ? best_idx_nxt : '0;
`endif
            if (accept && rmin_beat) begin
                best     <= best_nxt;
                best_tag <= best_tag_nxt;
                state    <= bus.in_last ? ST_IDLE : ST_ACCUM;
`ifdef FP_CMP_ARGMIN_IDX_EN
                best_idx <= best_idx_nxt;
                cnt      <= cnt_nxt;
`endif
            end

            // Stage s2: registered outputs; data only reloads on a valid s1 beat.
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_result    <= s1_reduce ? 1'b0 : s1_pred;
                bus.out_is_reduce <= s1_reduce;
                bus.out_sign      <= s1_val.sign;
                bus.out_exp       <= s1_val.exp;
                bus.out_frac      <= s1_val.frac;
                bus.out_tag       <= s1_tag;
`ifdef FP_CMP_ARGMIN_IDX_EN
                bus.out_idx       <= s1_idx;
`endif
            end
        end
    end

endmodule

// File: tb/tb_fp_cmp_reduce.sv
`timescale 1ns/1ps
module tb_fp_cmp_reduce;
    import fp_cmp_pkg::*;

    localparam int unsigned EXP_W  = 6;
    localparam int unsigned FRAC_W = 14;
    localparam int unsigned TAG_W  = 16;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned FW1    = FRAC_W + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_cmp_reduce_if #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W)
    ) bus ();

    fp_cmp_reduce #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W),
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic             result;
        logic             is_reduce;
        logic             sign;
        logic [EXP_W:0]   exp;
        logic [FRAC_W:0]  frac;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } out_t;

    typedef struct {
        out_t o;
        int   acc;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_out = 0;
    int   rdy_mode = 0;
    bit   chk_lat = 1'b0;
    bit   held = 1'b0;
    bit   accepted = 1'b0;
    out_t snap;
    out_t last_out;

    // Reference model state: the packet minimum as a real number plus its raw fields.
    bit               in_pkt = 1'b0;
    real              best_r;
    logic             best_sign;
    logic [EXP_W:0]   best_exp;
    logic [FRAC_W:0]  best_frac;
    logic [TAG_W-1:0] best_tag;
    int               best_idx;
    int               cnt;

    function automatic real to_real(input logic s, input logic [EXP_W:0] e,
                                    input logic [FRAC_W:0] f);
        int  k;
        real r;
        k = int'($signed(e)) - int'(FRAC_W);
        r = real'(f);
        if (k > 0) begin
            for (int i = 0; i < k; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -k; i++) r = r / 2.0;
        end
        return s ? -r : r;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.result    = bus.out_result;
        o.is_reduce = bus.out_is_reduce;
        o.sign      = bus.out_sign;
        o.exp       = bus.out_exp;
        o.frac      = bus.out_frac;
        o.tag       = bus.out_tag;
`ifdef FP_CMP_ARGMIN_IDX_EN
        o.idx       = bus.out_idx;
`else
        o.idx       = '0;
`endif
        return o;
    endfunction

    task automatic check_out(input string tag, input out_t obs, input out_t expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_accept();
        real  a;
        real  b;
        logic res;
        exp_t e;
        a = to_real(bus.sign_a, bus.exp_a, bus.frac_a);
        b = to_real(bus.sign_b, bus.exp_b, bus.frac_b);
        e.acc = cyc;
        e.o   = '0;
        if (!in_pkt && bus.op != 3'd6) begin
            case (bus.op)
                3'd1:    res = (a <= b);
                3'd2:    res = (a == b);
                3'd3:    res = (a != b);
                3'd4:    res = (a > b);
                3'd5:    res = (a >= b);
                default: res = (a < b);
            endcase
            e.o.result = res;
            e.o.sign   = bus.sign_a;
            e.o.exp    = bus.exp_a;
            e.o.frac   = bus.frac_a;
            e.o.tag    = bus.in_tag;
            exp_q.push_back(e);
        end else begin
            if (!in_pkt || a < best_r) begin
                best_r    = a;
                best_sign = bus.sign_a;
                best_exp  = bus.exp_a;
                best_frac = bus.frac_a;
                best_tag  = bus.in_tag;
                best_idx  = in_pkt ? cnt : 0;
            end
            cnt    = in_pkt ? (cnt + 1) % (1 << IDX_W) : 1;
            in_pkt = 1'b1;
            if (bus.in_last) begin
                in_pkt        = 1'b0;
                e.o.is_reduce = 1'b1;
                e.o.sign      = best_sign;
                e.o.exp       = best_exp;
                e.o.frac      = best_frac;
                e.o.tag       = best_tag;
`ifdef FP_CMP_ARGMIN_IDX_EN
                e.o.idx       = IDX_W'(best_idx);
`endif
                exp_q.push_back(e);
            end
        end
    endtask

    // One clock: sample at negedge, score outputs, feed the model, advance, pick out_ready.
    task automatic cycle();
        out_t o;
        exp_t e;
        @(negedge clk);
        o = sample();
        if (held) begin
            vectors++;
            assert (bus.out_valid === 1'b1 && o === snap) else begin
                miscompares++;
                $error("FAIL stall_hold: observed valid=%b %h expected valid=1 %h",
                       bus.out_valid, o, snap);
            end
        end
        held = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0) && !rst;
        snap = o;
        check_int("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
        if (bus.out_valid && bus.out_ready) begin
            n_out++;
            last_out = o;
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL spurious_out: observed %h expected no output", o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_out("out_data", o, e.o);
                if (chk_lat) check_int("latency", cyc - e.acc, 2);
            end
        end
        accepted = 1'b0;
        if (rst) begin
            exp_q.delete();
            in_pkt = 1'b0;
            cnt    = 0;
        end else if (bus.in_valid && bus.in_ready) begin
            model_accept();
            accepted = 1'b1;
        end
        @(posedge clk);
        cyc++;
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: bus.out_ready = ($urandom % 4) != 0;
        endcase
    endtask

    task automatic send(input logic [2:0] op, input logic last,
                        input logic sa, input int ea, input logic [FRAC_W:0] fa,
                        input logic sb, input int eb, input logic [FRAC_W:0] fb,
                        input logic [TAG_W-1:0] tag);
        bit done;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.in_last  = last;
        bus.sign_a   = sa;
        bus.exp_a    = ea[EXP_W:0];
        bus.frac_a   = fa;
        bus.sign_b   = sb;
        bus.exp_b    = eb[EXP_W:0];
        bus.frac_b   = fb;
        bus.in_tag   = tag;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            cycle();
            done = accepted;
        end
        check_int("accept_bound", int'(done), 1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cycle();
        check_int("drain_bound", exp_q.size(), 0);
    endtask

    task automatic rand_fp(output logic s, output int e, output logic [FRAC_W:0] f);
        s = 1'($urandom);
        e = int'($urandom_range(0, 8)) - 4;
        if ($urandom % 8 == 0) begin
            f = '0;
        end else begin
            // Few distinct mantissas so equal-frac and tie cases show up often.
            f = FW1'((1 << FRAC_W) | (($urandom % 8) << (FRAC_W - 3)));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n0;
        logic             sa, sb, last;
        int               ea, eb;
        logic [FRAC_W:0]  fa, fb;
        logic [2:0]       op;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.in_last   = 1'b0;
        bus.sign_a    = 1'b0;
        bus.exp_a     = '0;
        bus.frac_a    = '0;
        bus.sign_b    = 1'b0;
        bus.exp_b     = '0;
        bus.frac_b    = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        check_out("reset_outputs", sample(), '0);
        check_int("reset_out_valid", int'(bus.out_valid), 0);
        check_int("reset_in_ready", int'(bus.in_ready), 1);

        // Pairwise basics with latency checked against acceptance.
        chk_lat  = 1'b1;
        rdy_mode = 0;
        n0 = n_out;
        send(OP_LT, 1'b0, 1'b1, 0, 15'h6000, 1'b0, -2, 15'h4000, 16'd1);
        idle(); drain();
        check_int("lt_count", n_out - n0, 1);
        check_int("lt_neg15_vs_025", int'(last_out.result), 1);
        send(OP_GE, 1'b0, 1'b1, 0, 15'h6000, 1'b0, -2, 15'h4000, 16'd2);
        idle(); drain();
        check_int("ge_neg15_vs_025", int'(last_out.result), 0);
        check_int("ge_tag", int'(last_out.tag), 2);
        send(OP_EQ, 1'b0, 1'b0, 5, 15'h0000, 1'b1, -3, 15'h0000, 16'd3);
        idle(); drain();
        check_int("eq_pos0_neg0", int'(last_out.result), 1);
        send(OP_NE, 1'b0, 1'b0, 5, 15'h0000, 1'b1, -3, 15'h0000, 16'd4);
        idle(); drain();
        check_int("ne_pos0_neg0", int'(last_out.result), 0);

        // Negative ordering.
        send(OP_LT, 1'b0, 1'b1, 2, 15'h4000, 1'b1, 1, 15'h6000, 16'd5);
        idle(); drain();
        check_int("lt_neg4_neg3", int'(last_out.result), 1);
        send(OP_LT, 1'b0, 1'b1, 1, 15'h6000, 1'b1, 2, 15'h4000, 16'd6);
        idle(); drain();
        check_int("lt_neg3_neg4", int'(last_out.result), 0);
        send(OP_LT, 1'b0, 1'b1, 0, 15'h7000, 1'b1, 0, 15'h6000, 16'd7);
        idle(); drain();
        check_int("lt_neg175_neg15", int'(last_out.result), 1);
        check_int("lt_pairwise_not_reduce", int'(last_out.is_reduce), 0);

        // RMIN packet 3.0, -2.0, -2.0, 7.0: earliest -2.0 wins.
        n0 = n_out;
        send(OP_RMIN, 1'b0, 1'b0, 1, 15'h6000, 1'b0, 0, 15'h0000, 16'd10);
        send(OP_RMIN, 1'b0, 1'b1, 1, 15'h4000, 1'b0, 0, 15'h0000, 16'd11);
        send(OP_RMIN, 1'b0, 1'b1, 1, 15'h4000, 1'b0, 0, 15'h0000, 16'd12);
        send(OP_RMIN, 1'b1, 1'b0, 2, 15'h7000, 1'b0, 0, 15'h0000, 16'd13);
        idle(); drain();
        check_int("rmin_count", n_out - n0, 1);
        check_int("rmin_tag", int'(last_out.tag), 11);
        check_int("rmin_sign", int'(last_out.sign), 1);
        check_int("rmin_frac", int'(last_out.frac), 'h4000);
        check_int("rmin_is_reduce", int'(last_out.is_reduce), 1);
        check_int("rmin_result", int'(last_out.result), 0);
`ifdef FP_CMP_ARGMIN_IDX_EN
        check_int("rmin_idx", int'(last_out.idx), 1);
`endif

        // Streaming pairwise beats under 1,0,0,1 backpressure.
        chk_lat  = 1'b0;
        rdy_mode = 1;
        n0 = n_out;
        for (int i = 0; i < 8; i++) begin
            rand_fp(sa, ea, fa);
            rand_fp(sb, eb, fb);
            send(3'($urandom_range(0, 5)), 1'b0, sa, ea, fa, sb, eb, fb, 16'(100 + i));
        end
        idle(); drain();
        check_int("stream_count", n_out - n0, 8);
        check_int("stream_last_tag", int'(last_out.tag), 107);

        // Reset mid-packet discards the partial reduction.
        rdy_mode = 0;
        chk_lat  = 1'b1;
        send(OP_RMIN, 1'b0, 1'b1, 3, 15'h4000, 1'b0, 0, 15'h0000, 16'd50);
        send(OP_RMIN, 1'b0, 1'b1, 4, 15'h4000, 1'b0, 0, 15'h0000, 16'd51);
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_out("rst_mid_outputs", sample(), '0);
        n0 = n_out;
        send(OP_RMIN, 1'b1, 1'b0, 2, 15'h5000, 1'b0, 0, 15'h0000, 16'd99);
        idle(); drain();
        check_int("rst_pkt_count", n_out - n0, 1);
        check_int("rst_pkt_tag", int'(last_out.tag), 99);
        check_int("rst_pkt_frac", int'(last_out.frac), 'h5000);
        check_int("rst_pkt_exp", int'(last_out.exp), 2);
        check_int("rst_pkt_sign", int'(last_out.sign), 0);

        // Randomized mix of ops, packets, gaps and backpressure.
        chk_lat  = 1'b0;
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            rand_fp(sa, ea, fa);
            rand_fp(sb, eb, fb);
            if ($urandom % 8 == 0) begin
                sb = sa; eb = ea; fb = fa;
            end
            op   = 3'($urandom_range(0, 7));
            last = ($urandom % 4) == 0;
            send(op, last, sa, ea, fa, sb, eb, fb, 16'($urandom));
            if ($urandom % 5 == 0) begin
                idle();
                cycle();
            end
        end
        send(OP_RMIN, 1'b1, 1'b0, 0, 15'h4000, 1'b0, 0, 15'h0000, 16'hBEEF);
        idle(); drain();
        repeat (4) cycle();
        check_int("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fp_cmp_reduce.md
Name: fp_cmp_reduce

Overview:
- Parametrised, pipelined floating-point comparator for unpacked sign/exp/frac operands, with valid/ready handshake and backpressure.
- Per beat it either evaluates a pairwise relation (LT, LE, EQ, NE, GT, GE) or runs a streaming minimum reduction over a multi-beat packet.
- Serves the path tracer's intersection stage: closest-hit selection plus general float predicates.
- Comparison is exact; +0 and -0 compare equal.

Parameters:
- EXP_W, 6, exp port is a signed EXP_W+1-bit field (bits EXP_W:0).
- FRAC_W, 14, frac port is FRAC_W+1 bits (bits FRAC_W:0), hidden bit explicit.
- TAG_W, 16, user tag carried with each beat (e.g. triangle ID).
- IDX_W, 8, width of the beat-index counter; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- op  in  3  0=LT 1=LE 2=EQ 3=NE 4=GT 5=GE 6=RMIN; 7 is reserved and treated as LT.
- in_last  in  1  last beat of an RMIN packet; ignored for pairwise ops.
- sign_a/exp_a/frac_a  in  1/EXP_W+1/FRAC_W+1  operand A.
- sign_b/exp_b/frac_b  in  1/EXP_W+1/FRAC_W+1  operand B; ignored in RMIN.
- in_tag  in  TAG_W  beat tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_result  out  1  pairwise predicate result; 0 for RMIN outputs.
- out_is_reduce  out  1  output is an RMIN packet result.
- out_sign/out_exp/out_frac  out  1/EXP_W+1/FRAC_W+1  RMIN minimum (A is echoed for pairwise ops).
- out_tag  out  TAG_W  tag of the winning beat (RMIN) or the beat's tag (pairwise).

Behaviour:
- Reset: all outputs 0, state IDLE, best register cleared, s1_valid = s2_valid = 0. Reset mid-packet discards any partial reduction; no output is emitted for it.
- Zero: frac == 0, regardless of sign and exp. Two zeros compare equal.
- Ordering: signs differ (and not both zero) means the negative one is smaller. Same sign means compare exp as signed, then frac unsigned; the result is inverted when both operands are negative. Equal means both zero, or identical sign, exp and frac.
- Pipeline: two stages, s1 and s2.
  - Global stall = s2_valid && !out_ready.
  - in_ready = !stall, combinational from out_ready.
  - When not stalled, every stage advances.
  - Latency is 2 cycles from acceptance to out_valid.
  - Throughput is 1 beat/cycle.
- Stage s1:
  - Registers compare partials: sign_diff, exp_lt, exp_eq, frac_lt, frac_eq, zero_a, zero_b.
  - Registers op and tag.
  - Performs the RMIN update.
- Stage s2: registers the final predicate and drives the outputs. Outputs hold stable while stalled.
- RMIN state machine, states IDLE and ACCUM (a single-cycle compare against best):
  - IDLE, accepted RMIN beat: load best = A and best_tag = in_tag. Go to ACCUM unless in_last.
  - ACCUM, accepted beat: if A < best (strict), replace best. The earliest beat wins ties. The op field is ignored and the beat is treated as RMIN.
  - Accepted beat with in_last (either state): s1 marks an emit. s2 presents the updated best with out_is_reduce = 1. State returns to IDLE.
  - A single-beat packet (IDLE with in_last) emits A and its tag.
  - Pairwise beats in IDLE pass through and never touch best.
  - Non-last RMIN beats produce no output; s1 forwards a bubble.
- Back-to-back packets: a new packet's first beat in the cycle after a last beat starts fresh from IDLE, with no dead cycle.

Optional Feature:
- Macro FP_CMP_ARGMIN_IDX_EN.
- When defined:
  - Adds output out_idx (IDX_W), the zero-based index within the packet of the winning beat.
  - Adds an IDX_W beat counter, reset to 0 at packet start and on rst. It wraps modulo 2^IDX_W.
  - out_idx is 0 for pairwise outputs.
- When undefined: no out_idx port and no counter. All other behaviour is identical.

Decomposition:
- Package fp_cmp_pkg holds:
  - op encodings: OP_LT through OP_RMIN.
  - State encodings: ST_IDLE, ST_ACCUM.
  - Typedef fp_unpacked_t {sign, exp, frac}, parameterised by EXP_W/FRAC_W.
- One sub-module, fp_cmp_core: combinational magnitude/sign ordering producing lt and eq. It is instantiated twice: A vs B (pairwise) and A vs best (RMIN).

Test Plan:
- LT, A=-1.5, B=+0.25, out_ready=1 → out_valid 2 cycles after acceptance, out_result=1. Repeat with GE → 0.
- EQ, A=+0 (frac=0, exp=5), B=-0 (frac=0, exp=-3) → out_result=1. NE on the same operands → 0.
- RMIN packet of 4 beats with values 3.0, -2.0, -2.0, 7.0 and tags 10, 11, 12, 13, last on beat 4 → one output: -2.0, tag 11, out_is_reduce=1. With FP_CMP_ARGMIN_IDX_EN, out_idx=1.
- Streaming 8 pairwise beats with out_ready toggled 1,0,0,1,... → no beat lost or duplicated, order preserved, outputs stable while stalled, in_ready tracks out_ready when s2_valid.
- rst pulsed after 2 beats of an RMIN packet, then a 1-beat packet with A=5.0, tag 99, last=1 → only output is 5.0, tag 99.
- Negative ordering check: A=-4.0 vs B=-3.0 with LT → 1. A=-3.0 vs B=-4.0 with LT → 0. Same-exp negative case: A=-1.75 vs B=-1.5 with LT → 1.
